// File: rtl/spi_cmd_buffer.sv
// ============================================================================
// spi_cmd_buffer: opcode-driven FIFO/LED command processor behind spi_slave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_buffer #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 3,
  parameter int LED_W      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_data_available,
  input  logic [DATA_W+15:0]   rd_data,
  output logic                 rd_ack,
  input  logic                 wr_buffer_free,
  output logic                 wr_en,
  output logic [DATA_W+15:0]   wr_data,
  output logic [LED_W-1:0]     leds
);

  localparam int WORD_W = DATA_W + 16;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CNT_W  = DEPTH_LOG2 + 1;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_PUSH    = 8'h02;
  localparam logic [7:0] OP_POP     = 8'h03;
  localparam logic [7:0] OP_PEEK    = 8'h04;
  localparam logic [7:0] OP_WR_LEDS = 8'h05;
  localparam logic [7:0] OP_RD_LEDS = 8'h06;
  localparam logic [7:0] OP_STATUS  = 8'h07;
  localparam logic [7:0] OP_ILLEGAL = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_COMPOSE = 2'd2,
    S_SEND    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    rd_ack_q, rd_ack_d;
  logic                    wr_en_q, wr_en_d;
  logic [WORD_W-1:0]       wr_data_q, wr_data_d;
  logic [LED_W-1:0]        leds_q, leds_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic [7:0]              cmd_op_q, cmd_op_d;
  logic [DATA_W-1:0]       cmd_pl_q, cmd_pl_d;
  logic [7:0]              resp_op_q, resp_op_d;
  logic [DATA_W-1:0]       resp_data_q, resp_data_d;
  logic                    use_ram_q, use_ram_d;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DATA_W-1:0]       ram_rdata_q;
  logic                    mem_we;

  logic                    full, empty;
  logic [DATA_W-1:0]       leds_ext, count_ext;
  logic                    unused_bits;

  // The byte between opcode and payload carries nothing on the request side.
  assign unused_bits = ^rd_data[DATA_W+7:DATA_W];

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    leds_ext                = '0;
    leds_ext[LED_W-1:0]     = leds_q;
    count_ext               = '0;
    count_ext[CNT_W-1:0]    = count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_ack_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      leds_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      cmd_op_q    <= '0;
      cmd_pl_q    <= '0;
      resp_op_q   <= '0;
      resp_data_q <= '0;
      use_ram_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ack_q    <= rd_ack_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      leds_q      <= leds_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      cmd_op_q    <= cmd_op_d;
      cmd_pl_q    <= cmd_pl_d;
      resp_op_q   <= resp_op_d;
      resp_data_q <= resp_data_d;
      use_ram_q   <= use_ram_d;
    end
  end

  // Storage is not reset; the registered read captures the pre-command rd_ptr.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= cmd_pl_q;
    end
    if (state_q == S_EXEC) begin
      ram_rdata_q <= mem[rd_ptr_q];
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ack_d    = 1'b0;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    leds_d      = leds_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    cmd_op_d    = cmd_op_q;
    cmd_pl_d    = cmd_pl_q;
    resp_op_d   = resp_op_q;
    resp_data_d = resp_data_q;
    use_ram_d   = use_ram_q;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The slave needs a cycle to drop its level after an acknowledge.
        if (rd_data_available && !rd_ack_q) begin
          cmd_op_d = rd_data[WORD_W-1:WORD_W-8];
          cmd_pl_d = rd_data[DATA_W-1:0];
          rd_ack_d = 1'b1;
          state_d  = S_EXEC;
        end
      end

      S_EXEC: begin
        resp_op_d   = cmd_op_q;
        resp_data_d = '0;
        use_ram_d   = 1'b0;
        case (cmd_op_q)
          OP_NOP: ;
          OP_CLEAR: begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
          end
          OP_PUSH: begin
            resp_data_d = cmd_pl_q;
            if (!full) begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
              count_d  = count_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          OP_POP: begin
            if (!empty) begin
              use_ram_d = 1'b1;
              rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
              count_d   = count_q - CNT_W'(1);
            end else begin
              unf_d = 1'b1;
            end
          end
          OP_PEEK: begin
            use_ram_d = !empty;
          end
          OP_WR_LEDS: begin
            leds_d      = cmd_pl_q[LED_W-1:0];
            resp_data_d = cmd_pl_q;
          end
          OP_RD_LEDS: resp_data_d = leds_ext;
          OP_STATUS:  resp_data_d = count_ext;
          default:    resp_op_d   = OP_ILLEGAL;
        endcase
        state_d = S_COMPOSE;
      end

      S_COMPOSE: begin
        wr_data_d = {resp_op_q, ovf_q, unf_q, full, empty, 4'b0000,
                     use_ram_q ? ram_rdata_q : resp_data_q};
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (wr_buffer_free) begin
          wr_en_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rd_ack  = rd_ack_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign leds    = leds_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_buffer.sv
// ============================================================================
// tb_spi_cmd_buffer: directed + randomized checks of spi_cmd_buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_cmd_buffer;

  localparam int DATA_W = 16;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rd_data_available = 1'b0;
  logic [WORD_W-1:0] rd_data = '0;
  logic              rd_ack;
  logic              wr_buffer_free = 1'b1;
  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic [2:0]        leds;

  spi_cmd_buffer #(.DATA_W(DATA_W), .DEPTH_LOG2(3), .LED_W(3)) dut (
    .clk(clk), .reset(reset),
    .rd_data_available(rd_data_available), .rd_data(rd_data), .rd_ack(rd_ack),
    .wr_buffer_free(wr_buffer_free), .wr_en(wr_en), .wr_data(wr_data),
    .leds(leds)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int wr_cnt   = 0;
  int n_issued = 0;
  int n_done   = 0;
  logic [WORD_W-1:0] last_resp;

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;
  logic [2:0]        m_leds = 3'b000;

  always @(posedge clk) begin
    if (rd_ack === 1'b1) ack_cnt++;
    if (wr_en === 1'b1) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_exec(input logic [7:0] op, input logic [15:0] pl);
    logic [15:0] d;
    logic [7:0]  eop;
    d   = 16'h0000;
    eop = op;
    case (op)
      8'h00: ;
      8'h01: begin mq.delete(); m_ovf = 1'b0; m_unf = 1'b0; end
      8'h02: begin
        d = pl;
        if (mq.size() < DEPTH) mq.push_back(pl); else m_ovf = 1'b1;
      end
      8'h03: if (mq.size() > 0) d = mq.pop_front(); else m_unf = 1'b1;
      8'h04: if (mq.size() > 0) d = mq[0];
      8'h05: begin m_leds = pl[2:0]; d = pl; end
      8'h06: d = {13'b0, m_leds};
      8'h07: d = 16'(mq.size());
      default: eop = 8'hFF;
    endcase
    return {eop, m_ovf, m_unf, (mq.size() == DEPTH), (mq.size() == 0), 4'b0000, d};
  endfunction

  task automatic present(input logic [7:0] op, input logic [15:0] pl);
    @(negedge clk);
    rd_data = {op, 8'($urandom), pl};
    rd_data_available = 1'b1;
  endtask

  task automatic wait_ack(input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (rd_ack === 1'b1) begin got = 1'b1; break; end
    end
    rd_data_available = 1'b0;
    if (got) n_issued++;
    check({tag, "_ack"}, {31'b0, got}, 32'd1);
  endtask

  task automatic wait_wr(input string tag, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      lat++;
      if (wr_en === 1'b1) begin got = 1'b1; break; end
    end
    if (got) n_done++;
    check({tag, "_wr"}, {31'b0, got}, 32'd1);
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] op, input logic [15:0] pl,
                        input int stall);
    logic [31:0] exp;
    int lat;
    present(op, pl);
    wait_ack(tag);
    exp = model_exec(op, pl);
    if (stall > 0) begin
      wr_buffer_free = 1'b0;
      repeat (stall) @(posedge clk);
      #1 wr_buffer_free = 1'b1;
    end
    wait_wr(tag, lat);
    check({tag, "_data"}, wr_data, exp);
    if (stall == 0) check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_leds"}, {29'b0, leds}, {29'b0, m_leds});
    last_resp = wr_data;
  endtask

  initial begin
    logic [31:0] exp1, exp2;
    int lat, wr_seen, ack_seen, wr_snap;
    logic [7:0]  op;
    logic [15:0] pl;
    int r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_ack", {31'b0, rd_ack}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_leds", {29'b0, leds}, 32'd0);
    reset = 1'b0;

    // Push three, pop three
    do_cmd("push1", 8'h02, 16'h1111, 0);
    do_cmd("push2", 8'h02, 16'h2222, 0);
    do_cmd("push3", 8'h02, 16'h3333, 0);
    do_cmd("pop1", 8'h03, 16'h0, 0);
    check("pop1_val", {16'b0, last_resp[15:0]}, 32'h1111);
    do_cmd("pop2", 8'h03, 16'h0, 0);
    do_cmd("pop3", 8'h03, 16'h0, 0);
    check("pop3_word", last_resp, 32'h0310_3333);
    repeat (2) @(posedge clk);
    #1;
    check("ack_cnt6", ack_cnt, 32'd6);
    check("wr_cnt6", wr_cnt, 32'd6);

    // Fill to full and overflow
    for (int i = 0; i < 9; i++) begin
      do_cmd("fill", 8'h02, 16'(16'hA000 + i), 0);
      if (i == 7) check("push8_status", {24'b0, last_resp[23:16]}, 32'h20);
    end
    check("push9_status", {24'b0, last_resp[23:16]}, 32'hA0);
    do_cmd("status_full", 8'h07, 16'h0, 0);
    check("status_full_cnt", {16'b0, last_resp[15:0]}, 32'd8);
    do_cmd("clear", 8'h01, 16'h0, 0);
    check("clear_status", {24'b0, last_resp[23:16]}, 32'h10);
    do_cmd("status_empty", 8'h07, 16'h0, 0);

    // Underflow, sticky
    do_cmd("pop_empty", 8'h03, 16'h0, 0);
    check("pop_empty_word", last_resp, 32'h0350_0000);
    do_cmd("nop", 8'h00, 16'h0, 0);
    check("nop_status", {24'b0, last_resp[23:16]}, 32'h50);
    do_cmd("peek_empty", 8'h04, 16'h0, 0);

    // LEDs and illegal opcode
    do_cmd("wr_leds", 8'h05, 16'h0005, 0);
    check("leds_101", {29'b0, leds}, 32'd5);
    do_cmd("rd_leds", 8'h06, 16'h0, 0);
    do_cmd("illegal", 8'h2A, 16'hBEEF, 0);
    check("illegal_op", {24'b0, last_resp[31:24]}, 32'hFF);

    // Back-pressure with a second word pending
    do_cmd("clear2", 8'h01, 16'h0, 0);
    wr_buffer_free = 1'b0;
    present(8'h02, 16'h4242);
    wait_ack("bp_push");
    exp1 = model_exec(8'h02, 16'h4242);
    present(8'h07, 16'h0);
    wr_seen = 0;
    ack_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wr_en === 1'b1) wr_seen++;
      if (rd_ack === 1'b1) ack_seen++;
    end
    check("bp_no_wr", wr_seen, 32'd0);
    check("bp_no_ack", ack_seen, 32'd0);
    check("bp_held_data", wr_data, exp1);
    wr_buffer_free = 1'b1;
    wait_wr("bp_release", lat);
    check("bp_release_data", wr_data, exp1);
    check("bp_no_ack_yet", {31'b0, rd_ack}, 32'd0);
    wait_ack("bp_second");
    exp2 = model_exec(8'h07, 16'h0);
    wait_wr("bp_second", lat);
    check("bp_second_data", wr_data, exp2);
    check("bp_second_lat", lat, 32'd3);

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 99);
      pl = 16'($urandom);
      if      (r < 35) op = 8'h02;
      else if (r < 60) op = 8'h03;
      else if (r < 68) op = 8'h04;
      else if (r < 74) op = 8'h05;
      else if (r < 80) op = 8'h06;
      else if (r < 86) op = 8'h07;
      else if (r < 90) op = 8'h00;
      else if (r < 93) op = 8'h01;
      else             op = 8'($urandom_range(8, 255));
      do_cmd("rand", op, pl, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
    end

    // Reset while a response waits in SEND
    do_cmd("leds7", 8'h05, 16'h0007, 0);
    wr_buffer_free = 1'b0;
    present(8'h02, 16'h5A5A);
    wait_ack("abort_push");
    void'(model_exec(8'h02, 16'h5A5A));
    repeat (3) @(posedge clk);
    #1;
    wr_snap = wr_cnt;
    reset = 1'b1;
    #1;
    check("abort_wr_en", {31'b0, wr_en}, 32'd0);
    check("abort_leds", {29'b0, leds}, 32'd0);
    check("abort_wr_data", wr_data, 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_leds = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wr_buffer_free = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_wr", wr_cnt, wr_snap);
    do_cmd("abort_status", 8'h07, 16'h0, 0);
    check("abort_count0", {16'b0, last_resp[15:0]}, 32'd0);
    do_cmd("after_push", 8'h02, 16'h1234, 0);
    do_cmd("after_peek", 8'h04, 16'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("ack_total", ack_cnt, n_issued);
    check("wr_total", wr_cnt, n_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
